// File: rtl/didactic_uart_rx.sv
// Oversampling-free UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-byte holding register.
// Optional even-parity bit enabled by defining DIDACTIC_UART_RX_PARITY_EN (default build is 8N1).
module didactic_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [15:0] FULL_LD = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF_LD = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [2:0]  settle_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_bad_q, par_bad_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        deliver;
    logic        line;
    logic        tick;
    logic        fall;

    assign line = sync2_q;
    assign tick = (cnt_q == 16'd1);
    // The synchronizer resets to 1, so prev_q only reflects the real line once
    // three samples have passed; gating on settle_q stops a line held low
    // through reset from looking like a fresh falling edge.
    assign fall = settle_q[2] && prev_q && !sync2_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= '0;
        end else begin
            sync1_q  <= uart_rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef DIDACTIC_UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef DIDACTIC_UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d   = S_START;
                    cnt_d     = HALF_LD;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!line) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {line, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef DIDACTIC_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef DIDACTIC_UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (^{shift_q, line}) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                    state_d = S_STOP;
                    cnt_d   = FULL_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                // A frame already flagged for parity raises no second pulse here.
                if (tick) begin
                    if (line) begin
                        state_d = S_IDLE;
                        deliver = !par_bad_q;
                    end else begin
                        state_d     = S_BREAK_WAIT;
                        frame_err_d = !par_bad_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BREAK_WAIT: begin
                if (line) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (deliver) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_didactic_uart_rx.sv
// Scoreboard bench for didactic_uart_rx at CLKS_PER_BIT=16; honours DIDACTIC_UART_RX_PARITY_EN.
module tb_didactic_uart_rx;

    localparam int unsigned CPB = 16;
`ifdef DIDACTIC_UART_RX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    // Start bit driven just after edge 0: 2 sync flops + edge register put START at edge 3,
    // half-bit sample at edge 10, then one full bit per remaining bit, output one edge later.
    localparam int unsigned LAT = CPB * (NBITS - 1) + 11;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int unsigned cyc = 0;
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned fe_cnt = 0;
    int unsigned ov_cnt = 0;
    int unsigned pe_cnt = 0;
    logic        pv = 1'b0;
    logic        pa = 1'b0;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_data[$];
    int unsigned obs_cyc[$];

    didactic_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Record each newly delivered byte and accumulate pulse cycles.
    always @(negedge clk_in) begin
        if (rx_valid && (!pv || pa)) begin
            obs_data.push_back(rx_data);
            obs_cyc.push_back(cyc);
        end
        pv     <= rx_valid;
        pa     <= rx_valid && rx_ready;
        fe_cnt <= fe_cnt + (frame_err ? 1 : 0);
        ov_cnt <= ov_cnt + (overrun ? 1 : 0);
        pe_cnt <= pe_cnt + (parity_err ? 1 : 0);
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              output int unsigned start_cyc);
        logic pbit;
        pbit = (^d) ^ par_flip;
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef DIDACTIC_UART_RX_PARITY_EN
        send_bit(pbit);
`endif
        send_bit(stop_b);
    endtask

    task automatic idle(input int unsigned n);
        uart_rx = 1'b1;
        wait_cycles(n);
    endtask

    // Scoreboard drain: waits (bounded) for the next delivered byte and compares it.
    task automatic sb_expect_byte(input string name, output int unsigned got_cyc);
        int unsigned n;
        logic [7:0] want;
        logic [7:0] got;
        n = 0;
        got_cyc = 0;
        while (obs_data.size() == 0 && n < 400) begin
            wait_cycles(1);
            n++;
        end
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        total_cnt++;
        if (obs_data.size() == 0) begin
            $display("FAIL %s: no byte delivered within 400 cycles, want %h", name, want);
        end else begin
            got     = obs_data.pop_front();
            got_cyc = obs_cyc.pop_front();
            if (got !== want) $display("FAIL %s: rx_data got %h want %h", name, got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cycles(3);
        total_cnt++;
        if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000)
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b pe=%b want all 0",
                     rx_data, rx_valid, frame_err, overrun, parity_err);
        else pass_cnt++;
        reset = 1'b0;
        idle(10);
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic_hold;
        int unsigned sc, gc;
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, sc);
        sb_expect_byte("a5_data", gc);
        total_cnt++;
        if (gc - sc !== LAT) $display("FAIL a5_latency: got %0d want %0d", gc - sc, LAT);
        else pass_cnt++;
        idle(20);
        total_cnt++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
            $display("FAIL a5_hold: got v=%b data=%h want v=1 data=a5", rx_valid, rx_data);
        else pass_cnt++;
        rx_ready = 1'b1;
        wait_cycles(1);
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL a5_accept_clear: got %b want 0", rx_valid);
        else pass_cnt++;
    endtask

    task automatic test_false_start;
        int unsigned fe0, ov0, pe0, sc, gc;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        uart_rx = 1'b0;
        wait_cycles(4);
        idle(40);
        total_cnt++;
        if (obs_data.size() !== 0) $display("FAIL glitch_no_byte: got %0d bytes want 0", obs_data.size());
        else pass_cnt++;
        total_cnt++;
        if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0)
            $display("FAIL glitch_no_pulse: got %0d pulse cycles want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0);
        else pass_cnt++;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, sc);
        idle(20);
        sb_expect_byte("after_glitch_0f", gc);
    endtask

    task automatic test_frame_err;
        int unsigned fe0, sc, gc;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, sc);
        uart_rx = 1'b0;
        wait_cycles(40);
        total_cnt++;
        if (fe_cnt - fe0 !== 1) $display("FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt - fe0);
        else pass_cnt++;
        total_cnt++;
        if (obs_data.size() !== 0 || rx_valid !== 1'b0)
            $display("FAIL frame_err_no_byte: got %0d bytes v=%b want 0 0", obs_data.size(), rx_valid);
        else pass_cnt++;
        idle(20);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, sc);
        idle(20);
        sb_expect_byte("after_break_55", gc);
    endtask

    task automatic test_back_to_back;
        int unsigned ov0, sc, gc;
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, sc);
        send_frame(8'h22, 1'b1, 1'b0, sc);
        idle(10);
        sb_expect_byte("overrun_keep_11", gc);
        total_cnt++;
        if (ov_cnt - ov0 !== 1) $display("FAIL overrun_pulse: got %0d cycles want 1", ov_cnt - ov0);
        else pass_cnt++;
        total_cnt++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11 || obs_data.size() !== 0)
            $display("FAIL overrun_hold: got v=%b data=%h extra=%0d want 1 11 0", rx_valid, rx_data, obs_data.size());
        else pass_cnt++;
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        idle(5);
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 1'b0, sc);
        rx_ready = 1'b1;
        send_frame(8'h22, 1'b1, 1'b0, sc);
        idle(20);
        sb_expect_byte("drained_11", gc);
        sb_expect_byte("drained_22", gc);
        total_cnt++;
        if (ov_cnt - ov0 !== 0) $display("FAIL no_overrun: got %0d cycles want 0", ov_cnt - ov0);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int unsigned fe0, ov0, pe0, sc, gc;
        logic [7:0] d;
        d = 8'hFF;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        uart_rx = d[3];
        wait_cycles(8);
        reset = 1'b1;
        wait_cycles(1);
        total_cnt++;
        if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000)
            $display("FAIL midframe_reset: got data=%h v=%b fe=%b ov=%b pe=%b want all 0",
                     rx_data, rx_valid, frame_err, overrun, parity_err);
        else pass_cnt++;
        reset = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        wait_cycles(7);
        for (int i = 4; i < 8; i++) send_bit(d[i]);
`ifdef DIDACTIC_UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(1'b1);
        idle(20);
        total_cnt++;
        if (obs_data.size() !== 0) $display("FAIL abandoned_frame: got %0d bytes want 0", obs_data.size());
        else pass_cnt++;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, sc);
        idle(20);
        sb_expect_byte("after_reset_7e", gc);
        total_cnt++;
        if (fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0 !== 0)
            $display("FAIL after_reset_pulses: got %0d cycles want 0", fe_cnt - fe0 + ov_cnt - ov0 + pe_cnt - pe0);
        else pass_cnt++;
    endtask

`ifdef DIDACTIC_UART_RX_PARITY_EN
    task automatic test_parity;
        int unsigned pe0, fe0, sc, gc;
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h01, 1'b1, 1'b1, sc);
        idle(20);
        total_cnt++;
        if (pe_cnt - pe0 !== 1 || fe_cnt - fe0 !== 0)
            $display("FAIL parity_err_pulse: got pe=%0d fe=%0d want 1 0", pe_cnt - pe0, fe_cnt - fe0);
        else pass_cnt++;
        total_cnt++;
        if (obs_data.size() !== 0) $display("FAIL parity_no_byte: got %0d bytes want 0", obs_data.size());
        else pass_cnt++;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0, sc);
        idle(20);
        sb_expect_byte("parity_ok_01", gc);
    endtask
`else
    task automatic test_parity;
        total_cnt++;
        if (pe_cnt !== 0) $display("FAIL parity_tied: got %0d cycles want 0", pe_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic_hold();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_parity();
        total_cnt++;
        if (exp_q.size() !== 0 || obs_data.size() !== 0)
            $display("FAIL scoreboard_empty: got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_data.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/didactic_uart_rx.md
DIDACTIC_UART_RX -- requirements
Module: didactic_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk_in cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port uart_rx  input  1  asynchronous serial line from the SoC uart_tx; idle high.
REQ-005 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  byte available in holding register.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: new byte dropped because holding register full.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 when parity compiled out).

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-013 IDLE -> START on synchronized falling edge (previous sample 1, current 0); bit counter loaded for half-bit (CLKS_PER_BIT/2, truncated).
REQ-014 START: at half-bit, line 0 -> DATA with counter reloaded to CLKS_PER_BIT; line 1 -> IDLE (false start, no output pulse).
REQ-015 DATA: sample every CLKS_PER_BIT cycles, 8 bits LSB first into a shift register; after bit 7 -> PARITY if compiled in, else STOP.
REQ-016 STOP: sample at bit centre; 1 -> deliver byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> BREAK_WAIT.
REQ-017 BREAK_WAIT: stay until synchronized line is 1, then -> IDLE; no new start detected while low.
REQ-018 Delivery: holding register empty or drained same cycle (rx_valid&&rx_ready) -> rx_data loaded, rx_valid=1 on cycle after stop-bit sample.
REQ-019 Delivery with rx_valid=1 and rx_ready=0 -> overrun pulse, new byte dropped, old rx_data/rx_valid unchanged.
REQ-020 rx_valid SHALL clear the cycle after rx_valid&&rx_ready unless a new byte is delivered that cycle; rx_data SHALL not change while rx_valid=1 and unaccepted.
REQ-021 Bit-period counter SHALL count down to 1 and reload; no accumulated drift over a frame.
REQ-022 Only one of frame_err, overrun, parity_err SHALL pulse per frame.

Reset
REQ-023 On reset=1 at a clk_in edge: FSM -> IDLE, synchronizer flops -> 1, counters/shift register -> 0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
REQ-024 Reset mid-frame SHALL abandon the frame without any pulse; the receiver SHALL wait for the line high then a fresh falling edge.

Configuration
REQ-025 Macro DIDACTIC_UART_RX_PARITY_EN defined: one even-parity bit expected after bit 7 (PARITY state, sampled at bit centre); mismatch -> parity_err pulse, byte discarded, then STOP handled normally with no delivery.
REQ-026 Macro undefined: 8N1 framing, PARITY state unreachable, parity_err tied 0, port list unchanged.

Verification (bench CLKS_PER_BIT=16)
REQ-027 8N1 frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5 one cycle after stop sample, held until rx_ready=1, then rx_valid=0 next cycle.
REQ-028 uart_rx low for 4 cycles then high -> no rx_valid, no pulses, FSM back in IDLE; following frame 0x0F received correctly.
REQ-029 Frame 0x3C with stop bit 0, line held low 40 cycles -> frame_err one cycle, no rx_valid; after line high, frame 0x55 -> rx_data=0x55.
REQ-030 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 retained, overrun pulses once at 0x22 delivery; rx_ready held 1 during 0x22 instead -> rx_data=0x22, no overrun.
REQ-031 reset pulsed during data bit 3 of 0xFF -> all outputs 0 next cycle; next frame 0x7E -> rx_data=0x7E, no error pulses.
REQ-032 With DIDACTIC_UART_RX_PARITY_EN, frame 0x01 with parity bit 0 -> parity_err one cycle, no rx_valid; parity bit 1 -> rx_data=0x01.
